axi4_lite_master_read: RTL and testbench

AXI4-Lite read-channel initiator that turns a single-word read request from the core/cache side into an AR/R handshake sequence toward an AXI4-Lite slave, and returns the data and response status. It sits between the memory-request logic and the external read port. It is the counterpart of the slave-side read FSM, with one outstanding transaction at a time.

---
 rtl/axi4_lite_master_read.sv | 127 ++++++++++++
 tb/tb_axi4_lite_master_read.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_read.sv
// AXI4-Lite read initiator: one outstanding single-word read, AR then R handshake.
// Optional watchdog enabled by defining AXI4_LITE_MASTER_READ_TIMEOUT_EN.
`timescale 1ns/1ps
module axi4_lite_master_read #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      start_read_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic                      busy_o,
  output logic                      AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  output logic [2:0]                AR_PROT,
  input  logic                      AR_READY,
  output logic                      R_READY,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]                R_RESP,
  input  logic                      R_VALID,
  output logic [1:0]                state_o
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; AR_VALID/AR_ADDR hold until that edge, R_READY is only
  // raised in DATA, and neither ready nor valid depends on the other side.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   ar_hs, r_hs, timeout;

  assign ar_hs = (state_q == ADDR) && AR_READY;
  assign r_hs  = (state_q == DATA) && R_VALID;

`ifdef AXI4_LITE_MASTER_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter is zero whenever we leave IDLE, so entry to ADDR starts from zero.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || ar_hs) begin
      cnt_q <= '0;
    end else if (state_q == ADDR || state_q == DATA) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = ((state_q == ADDR && !AR_READY) || (state_q == DATA && !R_VALID))
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_read_i) state_d = ADDR;
      ADDR: if (ar_hs) state_d = DATA;
            else if (timeout) state_d = DONE;
      DATA: if (r_hs || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Status outputs are flops loaded from the next state so they stay glitch-free.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      AR_VALID <= 1'b0;
      R_READY  <= 1'b0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      AR_VALID <= (state_d == ADDR);
      R_READY  <= (state_d == DATA);
      done_o   <= (state_d == DONE);
      busy_o   <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      AR_ADDR <= '0;
    end else if (state_q == IDLE && start_read_i) begin
      AR_ADDR <= addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o  <= '0;
      error_o <= 1'b0;
    end else if (r_hs) begin
      data_o  <= R_DATA;
      error_o <= R_RESP[1];
    end else if (timeout) begin
      data_o  <= '0;
      error_o <= 1'b1;
    end
  end

  logic unused_resp;
  assign unused_resp = R_RESP[0];

  assign AR_PROT = 3'b000;
  assign state_o = state_q;

endmodule

// File: tb/tb_axi4_lite_master_read.sv
// Bench for axi4_lite_master_read: directed cases plus randomized reads against
// a latency/response model; define AXI4_LITE_MASTER_READ_TIMEOUT_EN for the watchdog case.
`timescale 1ns/1ps
module tb_axi4_lite_master_read;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          start_read_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_o;
  logic          done_o, error_o, busy_o;
  logic          AR_VALID, AR_READY, R_READY, R_VALID;
  logic [AW-1:0] AR_ADDR;
  logic [2:0]    AR_PROT;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic [1:0]    state_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int reads = 0;
  logic [DW:0] exp_q[$];

  axi4_lite_master_read #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arst_i(arst_i), .start_read_i(start_read_i), .addr_i(addr_i),
    .data_o(data_o), .done_o(done_o), .error_o(error_o), .busy_o(busy_o),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_READY(AR_READY),
    .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle. Expected latency is
  // 3 cycles plus one per stall cycle on each channel.
  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                         input logic [DW-1:0] data, input logic [1:0] resp,
                         input bit poke_start);
    int n;
    logic [DW:0] exp;
    start_read_i = 1'b1;
    addr_i = addr;
    exp_q.push_back({resp[1], data});
    reads++;
    step();
    start_read_i = 1'b0;
    addr_i = {$urandom, $urandom};
    n = cyc;
    for (int k = 0; k <= ar_dly; k++) begin
      AR_READY = (k == ar_dly);
      R_VALID  = 1'($urandom_range(0, 1));
      R_DATA   = $urandom;
      check("ar_valid", 64'(AR_VALID), 64'd1);
      check("ar_addr", AR_ADDR, addr);
      check("r_ready_in_addr", 64'(R_READY), 64'd0);
      check("busy_in_addr", 64'(busy_o), 64'd1);
      step();
    end
    AR_READY = 1'b0;
    for (int k = 0; k <= r_dly; k++) begin
      R_VALID = (k == r_dly);
      R_DATA  = (k == r_dly) ? data : $urandom;
      R_RESP  = (k == r_dly) ? resp : 2'($urandom);
      if (poke_start && k == 0) begin
        start_read_i = 1'b1;
        addr_i = 64'h2000;
      end else begin
        start_read_i = 1'b0;
      end
      check("r_ready", 64'(R_READY), 64'd1);
      check("ar_valid_in_data", 64'(AR_VALID), 64'd0);
      check("done_early", 64'(done_o), 64'd0);
      step();
    end
    R_VALID = 1'b0;
    start_read_i = 1'b0;
    check("done", 64'(done_o), 64'd1);
    check("latency", 64'((cyc - n) + 1), 64'(3 + ar_dly + r_dly));
    exp = exp_q.pop_front();
    check("data", 64'(data_o), 64'(exp[DW-1:0]));
    check("error", 64'(error_o), 64'(exp[DW]));
    check("busy_in_done", 64'(busy_o), 64'd1);
    step();
    check("done_pulse_width", 64'(done_o), 64'd0);
    check("busy_idle", 64'(busy_o), 64'd0);
    check("no_second_ar", 64'(AR_VALID), 64'd0);
  endtask

  initial begin
    arst_i = 1'b1;
    start_read_i = 1'b0;
    addr_i = '0;
    AR_READY = 1'b0;
    R_VALID = 1'b0;
    R_DATA = '0;
    R_RESP = 2'b00;
    #1;
    check("rst_ar_valid", 64'(AR_VALID), 64'd0);
    check("rst_ar_addr", AR_ADDR, 64'd0);
    check("rst_ar_prot", 64'(AR_PROT), 64'd0);
    check("rst_r_ready", 64'(R_READY), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_i = 1'b0;
    step();

    do_read(64'h1000, 0, 0, 32'hDEADBEEF, 2'b00, 1'b0);
    do_read(64'h1234_5678_9ABC_DEF0, 4, 2, 32'hCAFEF00D, 2'b01, 1'b0);
    do_read(64'h40, 1, 0, 32'h12345678, 2'b10, 1'b0);
    do_read(64'h44, 0, 1, 32'h12345678, 2'b11, 1'b0);
    do_read(64'h1800, 0, 2, 32'hA5A5A5A5, 2'b00, 1'b1);
    do_read(64'h2000, 0, 0, 32'h5A5A5A5A, 2'b00, 1'b0);

    // Reset while AR_VALID is up; the aborted read must not pulse done.
    start_read_i = 1'b1;
    addr_i = 64'h3000;
    step();
    start_read_i = 1'b0;
    check("pre_rst_ar_valid", 64'(AR_VALID), 64'd1);
    arst_i = 1'b1;
    #1;
    check("mid_rst_ar_valid", 64'(AR_VALID), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    arst_i = 1'b0;
    step();
    check("post_rst_idle", 64'(AR_VALID), 64'd0);
    do_read(64'h3004, 2, 1, 32'h0BADC0DE, 2'b00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_read({$urandom, $urandom}, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef AXI4_LITE_MASTER_READ_TIMEOUT_EN
    start_read_i = 1'b1;
    addr_i = 64'h5000;
    reads++;
    step();
    start_read_i = 1'b0;
    AR_READY = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("to_ar_valid", 64'(AR_VALID), 64'd1);
      check("to_done_early", 64'(done_o), 64'd0);
      step();
    end
    check("to_done", 64'(done_o), 64'd1);
    check("to_error", 64'(error_o), 64'd1);
    check("to_data", 64'(data_o), 64'd0);
    check("to_ar_valid_drop", 64'(AR_VALID), 64'd0);
    step();
    check("to_idle", 64'(AR_VALID), 64'd0);
    check("to_busy", 64'(busy_o), 64'd0);
`endif

    check("done_pulses", 64'(done_cnt), 64'(reads));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
